// File: rtl/irq_coalesce_ctrl.sv
// Interrupt aggregator: masks W1C status bits and merges them into one CPU
// interrupt, optionally coalesced by event-count threshold or timeout.
module irq_coalesce_ctrl #(
    parameter int NUM_SRC   = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 RegClk,
    input  logic                 RegReset,
    input  logic [NUM_SRC-1:0]   irq_status,
    input  logic [NUM_SRC-1:0]   irq_enable,
    input  logic                 coal_en,
    input  logic [CNT_WIDTH-1:0] coal_threshold,
    input  logic [CNT_WIDTH-1:0] coal_timeout,
    input  logic                 irq_ack,
    output logic                 irq_out,
    output logic [NUM_SRC-1:0]   irq_src,
    output logic [CNT_WIDTH-1:0] event_cnt,
    output logic [1:0]           irq_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ASSERT  = 2'd2
    } state_t;

    // Sum width is wide enough that count + popcount never overflows before saturation.
    localparam int SW = CNT_WIDTH + $clog2(NUM_SRC + 1) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    function automatic logic [SW-1:0] popcount(input logic [NUM_SRC-1:0] v);
        logic [SW-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            acc = acc + SW'(v[i]);
        end
        return acc;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat(input logic [SW-1:0] v);
        return (v > SW'(CNT_MAX)) ? CNT_MAX : v[CNT_WIDTH-1:0];
    endfunction

    state_t               state, state_n;
    logic [NUM_SRC-1:0]   masked, masked_q, rise, src_n;
    logic [CNT_WIDTH-1:0] timer, timer_n, timer_inc, cnt_n, cnt_rise;

    always_comb begin
        masked    = irq_status & irq_enable;
        rise      = masked & ~masked_q;
        cnt_rise  = sat(SW'(event_cnt) + popcount(rise));
        timer_inc = (timer == CNT_MAX) ? timer : timer + CNT_WIDTH'(1);

        state_n = state;
        cnt_n   = event_cnt;
        timer_n = timer;
        src_n   = irq_src;

        case (state)
            IDLE: begin
                if (|masked) begin
                    if (coal_en) begin
                        state_n = COLLECT;
                        cnt_n   = sat(popcount(masked));
                        timer_n = '0;
                    end else begin
                        state_n = ASSERT;
                        src_n   = masked;
                    end
                end
            end
            COLLECT: begin
                if (masked == '0) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    timer_n = '0;
                end else begin
                    // A rise coinciding with release is still counted.
                    cnt_n = cnt_rise;
                    if (!coal_en || event_cnt >= coal_threshold || timer >= coal_timeout) begin
                        state_n = ASSERT;
                        src_n   = masked;
                    end else begin
                        timer_n = timer_inc;
                    end
                end
            end
            ASSERT: begin
                if (irq_ack || masked == '0) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    timer_n = '0;
                end else begin
                    cnt_n = cnt_rise;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge RegClk or posedge RegReset) begin
        if (RegReset) begin
            state     <= IDLE;
            masked_q  <= '0;
            event_cnt <= '0;
            timer     <= '0;
            irq_src   <= '0;
        end else begin
            state     <= state_n;
            masked_q  <= masked;
            event_cnt <= cnt_n;
            timer     <= timer_n;
            irq_src   <= src_n;
        end
    end

    assign irq_out   = (state == ASSERT);
    assign irq_state = state;

endmodule

// File: tb/tb_irq_coalesce_ctrl.sv
// Bench for irq_coalesce_ctrl: directed scenarios plus randomized traffic
// against an arithmetic reference model, on an 8-bit and a 2-bit counter instance.
module tb_irq_coalesce_ctrl;

    logic       RegClk, RegReset;
    logic [7:0] irq_status, irq_enable, coal_threshold, coal_timeout;
    logic [1:0] thr2, tmo2;
    logic       coal_en, irq_ack;

    logic       out_a, out_b;
    logic [7:0] src_a, src_b, cnt_a;
    logic [1:0] cnt_b, st_a, st_b;

    int vectors = 0;
    int errors  = 0;

    // Reference model state, index 0 = 8-bit counters, 1 = 2-bit counters.
    int         m_st[2], m_cnt[2], m_tmr[2];
    logic [7:0] m_mq[2], m_src[2];
    int         cap[2] = '{255, 3};

    irq_coalesce_ctrl #(.NUM_SRC(8), .CNT_WIDTH(8)) dut_a (
        .RegClk(RegClk), .RegReset(RegReset), .irq_status(irq_status), .irq_enable(irq_enable),
        .coal_en(coal_en), .coal_threshold(coal_threshold), .coal_timeout(coal_timeout),
        .irq_ack(irq_ack), .irq_out(out_a), .irq_src(src_a), .event_cnt(cnt_a), .irq_state(st_a)
    );

    irq_coalesce_ctrl #(.NUM_SRC(8), .CNT_WIDTH(2)) dut_b (
        .RegClk(RegClk), .RegReset(RegReset), .irq_status(irq_status), .irq_enable(irq_enable),
        .coal_en(coal_en), .coal_threshold(thr2), .coal_timeout(tmo2),
        .irq_ack(irq_ack), .irq_out(out_b), .irq_src(src_b), .event_cnt(cnt_b), .irq_state(st_b)
    );

    initial RegClk = 1'b0;
    always #5 RegClk = ~RegClk;

    function automatic int satv(int v, int c);
        return (v > c) ? c : v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_cnt[k] = 0; m_tmr[k] = 0; m_mq[k] = '0; m_src[k] = '0;
        end
    endtask

    // Advance one clock; model next-state is computed from the inputs held across the edge.
    task automatic step();
        int         n_st[2], n_cnt[2], n_tmr[2];
        logic [7:0] n_src[2];
        logic [7:0] masked, rise;
        int         pm, pr, thr, tmo;
        masked = irq_status & irq_enable;
        for (int k = 0; k < 2; k++) begin
            rise = masked & ~m_mq[k];
            pm = $countones(masked);
            pr = $countones(rise);
            thr = (k == 0) ? int'(coal_threshold) : int'(thr2);
            tmo = (k == 0) ? int'(coal_timeout) : int'(tmo2);
            n_st[k] = m_st[k]; n_cnt[k] = m_cnt[k]; n_tmr[k] = m_tmr[k]; n_src[k] = m_src[k];
            if (m_st[k] == 0) begin
                if (masked != 0) begin
                    if (coal_en) begin
                        n_st[k] = 1; n_cnt[k] = satv(pm, cap[k]); n_tmr[k] = 0;
                    end else begin
                        n_st[k] = 2; n_src[k] = masked;
                    end
                end
            end else if (m_st[k] == 1) begin
                if (masked == 0) begin
                    n_st[k] = 0; n_cnt[k] = 0; n_tmr[k] = 0;
                end else begin
                    n_cnt[k] = satv(m_cnt[k] + pr, cap[k]);
                    if (!coal_en || m_cnt[k] >= thr || m_tmr[k] >= tmo) begin
                        n_st[k] = 2; n_src[k] = masked;
                    end else begin
                        n_tmr[k] = satv(m_tmr[k] + 1, cap[k]);
                    end
                end
            end else begin
                if (irq_ack || masked == 0) begin
                    n_st[k] = 0; n_cnt[k] = 0; n_tmr[k] = 0;
                end else begin
                    n_cnt[k] = satv(m_cnt[k] + pr, cap[k]);
                end
            end
        end
        @(posedge RegClk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_st[k] = n_st[k]; m_cnt[k] = n_cnt[k]; m_tmr[k] = n_tmr[k];
            m_src[k] = n_src[k]; m_mq[k] = masked;
        end
    endtask

    task automatic apply_reset();
        irq_status = '0; irq_enable = '0; irq_ack = 1'b0; coal_en = 1'b0;
        coal_threshold = 8'hFF; coal_timeout = 8'hFF; thr2 = 2'd3; tmo2 = 2'd3;
        RegReset = 1'b1;
        model_reset();
        repeat (2) @(posedge RegClk);
        #1;
        RegReset = 1'b0;
    endtask

    task automatic test_reset();
        RegReset = 1'b1;
        #1;
        vectors++;
        if ({out_a, st_a, cnt_a, src_a, out_b, st_b, cnt_b, src_b} !== 31'h0) begin
            errors++;
            $display("FAIL reset_values: got %h expected 0", {out_a, st_a, cnt_a, src_a, out_b, st_b, cnt_b, src_b});
        end
        apply_reset();
    endtask

    task automatic test_immediate();
        apply_reset();
        irq_enable = 8'h01;
        step(); step();
        irq_status = 8'h01;
        vectors++;
        if ({out_a, st_a} !== 3'b0_00) begin
            errors++; $display("FAIL imm_no_early: got %b expected 000", {out_a, st_a});
        end
        step();
        vectors++;
        if ({out_a, st_a, src_a} !== {1'b1, 2'd2, 8'h01}) begin
            errors++; $display("FAIL imm_assert: got %h expected %h", {out_a, st_a, src_a}, {1'b1, 2'd2, 8'h01});
        end
        step(); step();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        vectors++;
        if ({out_a, st_a} !== 3'b0_00) begin
            errors++; $display("FAIL imm_ack_drop: got %b expected 000", {out_a, st_a});
        end
        step();
        vectors++;
        if ({out_a, st_a, src_a} !== {1'b1, 2'd2, 8'h01}) begin
            errors++; $display("FAIL imm_rearm: got %h expected %h", {out_a, st_a, src_a}, {1'b1, 2'd2, 8'h01});
        end
        irq_status = 8'h00;
        step();
        vectors++;
        if ({out_a, st_a} !== 3'b0_00) begin
            errors++; $display("FAIL imm_auto_deassert: got %b expected 000", {out_a, st_a});
        end
    endtask

    task automatic test_threshold();
        apply_reset();
        coal_en = 1'b1; coal_threshold = 8'd3; coal_timeout = 8'hFF; irq_enable = 8'hFF;
        irq_status = 8'h01;
        step();
        vectors++;
        if ({out_a, st_a, cnt_a} !== {1'b0, 2'd1, 8'd1}) begin
            errors++; $display("FAIL thr_enter: got %h expected %h", {out_a, st_a, cnt_a}, {1'b0, 2'd1, 8'd1});
        end
        step();
        irq_status = 8'h03;
        step();
        vectors++;
        if ({out_a, st_a, cnt_a} !== {1'b0, 2'd1, 8'd2}) begin
            errors++; $display("FAIL thr_cnt2: got %h expected %h", {out_a, st_a, cnt_a}, {1'b0, 2'd1, 8'd2});
        end
        step();
        irq_status = 8'h07;
        step();
        vectors++;
        if ({out_a, st_a, cnt_a} !== {1'b0, 2'd1, 8'd3}) begin
            errors++; $display("FAIL thr_cnt3: got %h expected %h", {out_a, st_a, cnt_a}, {1'b0, 2'd1, 8'd3});
        end
        step();
        vectors++;
        if ({out_a, st_a, cnt_a, src_a} !== {1'b1, 2'd2, 8'd3, 8'h07}) begin
            errors++; $display("FAIL thr_release: got %h expected %h", {out_a, st_a, cnt_a, src_a}, {1'b1, 2'd2, 8'd3, 8'h07});
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        coal_en = 1'b1; coal_threshold = 8'hFF; coal_timeout = 8'd3; irq_enable = 8'hFF;
        irq_status = 8'h10;
        step();
        vectors++;
        if ({out_a, st_a, cnt_a} !== {1'b0, 2'd1, 8'd1}) begin
            errors++; $display("FAIL tmo_enter: got %h expected %h", {out_a, st_a, cnt_a}, {1'b0, 2'd1, 8'd1});
        end
        for (int i = 0; i < 3; i++) begin
            irq_ack = (i == 1);
            step();
            vectors++;
            if ({out_a, st_a} !== {1'b0, 2'd1}) begin
                errors++; $display("FAIL tmo_wait_%0d: got %b expected 001", i, {out_a, st_a});
            end
        end
        irq_ack = 1'b0;
        step();
        vectors++;
        if ({out_a, st_a, cnt_a, src_a} !== {1'b1, 2'd2, 8'd1, 8'h10}) begin
            errors++; $display("FAIL tmo_release: got %h expected %h", {out_a, st_a, cnt_a, src_a}, {1'b1, 2'd2, 8'd1, 8'h10});
        end
    endtask

    task automatic test_w1c_clear();
        apply_reset();
        coal_en = 1'b1; irq_enable = 8'hFF;
        irq_status = 8'h20;
        step(); step();
        irq_status = 8'h00;
        step();
        vectors++;
        if ({out_a, st_a, cnt_a} !== 11'h0) begin
            errors++; $display("FAIL w1c_collect: got %h expected 0", {out_a, st_a, cnt_a});
        end
        step();
        vectors++;
        if ({out_a, st_a, cnt_a} !== 11'h0) begin
            errors++; $display("FAIL w1c_collect_stay: got %h expected 0", {out_a, st_a, cnt_a});
        end
        coal_en = 1'b0;
        irq_status = 8'h20;
        step();
        irq_status = 8'h00;
        step();
        vectors++;
        if ({out_a, st_a} !== 3'b0_00) begin
            errors++; $display("FAIL w1c_assert: got %b expected 000", {out_a, st_a});
        end
        irq_status = 8'h20;
        step();
        irq_ack = 1'b1; irq_status = 8'h00;
        step();
        irq_ack = 1'b0;
        step();
        vectors++;
        if ({out_a, st_a} !== 3'b0_00) begin
            errors++; $display("FAIL ack_and_clear: got %b expected 000", {out_a, st_a});
        end
    endtask

    task automatic test_zero_threshold();
        apply_reset();
        coal_en = 1'b1; coal_threshold = 8'd0; irq_enable = 8'hFF;
        irq_status = 8'h02;
        step();
        vectors++;
        if ({out_a, st_a} !== {1'b0, 2'd1}) begin
            errors++; $display("FAIL zero_thr_collect: got %b expected 001", {out_a, st_a});
        end
        step();
        vectors++;
        if ({out_a, st_a} !== {1'b1, 2'd2}) begin
            errors++; $display("FAIL zero_thr_release: got %b expected 110", {out_a, st_a});
        end
    endtask

    task automatic test_mask_saturation();
        apply_reset();
        irq_status = 8'hFF;
        repeat (3) step();
        vectors++;
        if ({out_a, st_a, out_b, st_b} !== 6'h0) begin
            errors++; $display("FAIL masked_idle: got %b expected 000000", {out_a, st_a, out_b, st_b});
        end
        irq_enable = 8'hFF; coal_en = 1'b1;
        step();
        vectors++;
        if ({st_a, cnt_a, st_b, cnt_b} !== {2'd1, 8'd8, 2'd1, 2'd3}) begin
            errors++; $display("FAIL sat_load: got %h expected %h", {st_a, cnt_a, st_b, cnt_b}, {2'd1, 8'd8, 2'd1, 2'd3});
        end
        step();
        for (int i = 0; i < 4; i++) begin
            irq_status = 8'h01;
            step();
            irq_status = 8'hFF;
            step();
        end
        vectors++;
        if ({st_a, cnt_a, out_b, st_b, cnt_b} !== {2'd1, 8'd36, 1'b1, 2'd2, 2'd3}) begin
            errors++; $display("FAIL sat_hold: got %h expected %h", {st_a, cnt_a, out_b, st_b, cnt_b}, {2'd1, 8'd36, 1'b1, 2'd2, 2'd3});
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        coal_en = 1'b1; irq_enable = 8'hFF;
        irq_status = 8'h04;
        step(); step();
        #2 RegReset = 1'b1;
        #1;
        vectors++;
        if ({out_a, st_a, cnt_a, src_a, out_b, st_b, cnt_b, src_b} !== 31'h0) begin
            errors++; $display("FAIL rst_mid_collect: got %h expected 0", {out_a, st_a, cnt_a, src_a, out_b, st_b, cnt_b, src_b});
        end
        model_reset();
        irq_status = 8'h00;
        #2 RegReset = 1'b0;
        step();
        vectors++;
        if ({out_a, st_a} !== 3'b0_00) begin
            errors++; $display("FAIL rst_no_irq: got %b expected 000", {out_a, st_a});
        end
        coal_en = 1'b0;
        irq_status = 8'h04;
        step();
        #2 RegReset = 1'b1;
        #1;
        vectors++;
        if ({out_a, st_a, cnt_a, src_a} !== 19'h0) begin
            errors++; $display("FAIL rst_mid_assert: got %h expected 0", {out_a, st_a, cnt_a, src_a});
        end
        model_reset();
        #2 RegReset = 1'b0;
        step();
        vectors++;
        if ({out_a, st_a, src_a} !== {1'b1, 2'd2, 8'h04}) begin
            errors++; $display("FAIL rst_resume: got %h expected %h", {out_a, st_a, src_a}, {1'b1, 2'd2, 8'h04});
        end
    endtask

    task automatic test_random();
        apply_reset();
        irq_enable = 8'hFF; coal_en = 1'b1;
        coal_threshold = 8'd3; coal_timeout = 8'd5;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) irq_enable = 8'($urandom);
            if ($urandom_range(0, 31) == 0) coal_en = ~coal_en;
            if ($urandom_range(0, 15) == 0) begin
                coal_threshold = 8'($urandom_range(0, 6));
                coal_timeout   = 8'($urandom_range(0, 12));
                thr2 = 2'($urandom_range(0, 3));
                tmo2 = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) == 0) irq_status = irq_status | (8'h01 << $urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) irq_status = irq_status & 8'($urandom);
            if ($urandom_range(0, 40) == 0) irq_status = 8'h00;
            irq_ack = ($urandom_range(0, 7) == 0);
            step();
            vectors++;
            if (out_a !== (m_st[0] == 2)) begin
                errors++; $display("FAIL rnd_a_out @%0d: got %b expected %b", n, out_a, (m_st[0] == 2));
            end
            vectors++;
            if (st_a !== 2'(m_st[0])) begin
                errors++; $display("FAIL rnd_a_state @%0d: got %0d expected %0d", n, st_a, m_st[0]);
            end
            vectors++;
            if (cnt_a !== 8'(m_cnt[0])) begin
                errors++; $display("FAIL rnd_a_cnt @%0d: got %0d expected %0d", n, cnt_a, m_cnt[0]);
            end
            vectors++;
            if (src_a !== m_src[0]) begin
                errors++; $display("FAIL rnd_a_src @%0d: got %h expected %h", n, src_a, m_src[0]);
            end
            vectors++;
            if (out_b !== (m_st[1] == 2)) begin
                errors++; $display("FAIL rnd_b_out @%0d: got %b expected %b", n, out_b, (m_st[1] == 2));
            end
            vectors++;
            if (st_b !== 2'(m_st[1])) begin
                errors++; $display("FAIL rnd_b_state @%0d: got %0d expected %0d", n, st_b, m_st[1]);
            end
            vectors++;
            if (cnt_b !== 2'(m_cnt[1])) begin
                errors++; $display("FAIL rnd_b_cnt @%0d: got %0d expected %0d", n, cnt_b, m_cnt[1]);
            end
            vectors++;
            if (src_b !== m_src[1]) begin
                errors++; $display("FAIL rnd_b_src @%0d: got %h expected %h", n, src_b, m_src[1]);
            end
        end
        irq_ack = 1'b0;
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_immediate();
        test_threshold();
        test_timeout();
        test_w1c_clear();
        test_zero_threshold();
        test_mask_saturation();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/irq_coalesce_ctrl.md
Name: irq_coalesce_ctrl

Overview:
Downstream consumer of the W1C status outputs produced by the register block (w1c_out_* bits). It masks those status bits with software enables and merges them into a single interrupt line to the CPU. It can hold that interrupt back, releasing it only after an event-count threshold or a timeout is reached (interrupt coalescing). Debug outputs expose state, event count and the sources latched at assertion.

Parameters:
NUM_SRC, 8, number of W1C status inputs aggregated
CNT_WIDTH, 8, width of the event counter, timer, threshold and timeout

Ports:
RegClk  input  1  block clock, same domain as the register block
RegReset  input  1  asynchronous, active-high reset
irq_status  input  NUM_SRC  W1C status bits (level, stay high until software W1C clears them), RegClk domain
irq_enable  input  NUM_SRC  per-source enable (swi register field)
coal_en  input  1  1 = coalescing on; 0 = immediate mode
coal_threshold  input  CNT_WIDTH  event count that releases the interrupt
coal_timeout  input  CNT_WIDTH  cycles in COLLECT before forced release
irq_ack  input  1  single-cycle acknowledge pulse (software write strobe)
irq_out  output  1  interrupt to CPU, registered
irq_src  output  NUM_SRC  masked sources captured on entry to ASSERT
event_cnt  output  CNT_WIDTH  coalesced event count, for the debug bus
irq_state  output  2  FSM state: 0=IDLE, 1=COLLECT, 2=ASSERT

Behaviour:
- Clock and reset: one clock, RegClk. RegReset is asynchronous and active-high.
- Reset values: all flops 0. irq_out=0, irq_src=0, event_cnt=0, irq_state=IDLE, timer=0, masked_q=0.
- Masking: masked = irq_status & irq_enable. masked_q is masked registered one cycle. rise = masked & ~masked_q. Rising edges are counted with popcount(rise).
- IDLE:
  - If |masked and coal_en=0: go to ASSERT.
  - If |masked and coal_en=1: go to COLLECT. Load event_cnt = popcount(masked) and set timer=0.
  - Otherwise stay in IDLE.
- COLLECT (decisions use registered values):
  - If masked==0 (all sources cleared by W1C): go to IDLE, clear event_cnt and timer.
  - Else if coal_en=0, or event_cnt >= coal_threshold, or timer >= coal_timeout: go to ASSERT.
  - Else stay in COLLECT. timer increments by 1. event_cnt increments by popcount(rise).
  - timer and event_cnt saturate at all-ones and never wrap.
- ASSERT:
  - irq_out=1. irq_src is loaded with masked on the entry transition and is held.
  - irq_ack=1: go to IDLE, clear event_cnt and timer. If sources are still pending, IDLE re-arms on the next cycle, so irq_out is low for at least 1 cycle.
  - masked==0 with no ack: auto-deassert to IDLE the same way.
  - New rises while in ASSERT keep incrementing event_cnt (saturating) for debug only.
- irq_out equals (state==ASSERT) and is taken from the state register, so it is glitch-free.
- Latency, immediate mode: a masked bit seen at cycle N gives irq_out=1 at cycle N+1.
- Latency, coalescing mode: COLLECT is entered at N+1 with timer=0. Worst case irq_out=1 at N+2+coal_timeout.
- Threshold or timeout of 0: release on the first COLLECT cycle, irq_out at N+2.
- Simultaneous events:
  - irq_ack while not in ASSERT is ignored.
  - irq_ack and masked==0 in the same ASSERT cycle: go to IDLE (both paths agree).
  - A rise in the same cycle as the COLLECT release: the count updates, and the transition still happens.
- Mid-operation changes:
  - Clearing irq_enable mid-COLLECT is treated as masked==0 and returns to IDLE.
  - Changing threshold or timeout mid-COLLECT takes effect on the next comparison.
- Reset mid-operation: asynchronous return to IDLE with all outputs 0. No interrupt is emitted from pre-reset state.

Test Plan:
- Immediate mode: coal_en=0, irq_enable=8'h01; raise irq_status[0] at cycle 10 -> irq_out=1 at 11, irq_src=8'h01, irq_state=2. Pulse irq_ack at 15 with status still high -> irq_out=0 at 16, irq_out=1 again at 17.
- Threshold release: coal_en=1, threshold=3, timeout=8'hFF, enable=8'hFF. Raise bits 0,1,2 on cycles 10,12,14 -> event_cnt reaches 3 at 15, irq_out=1 at 16, irq_src=8'h07.
- Timeout release: coal_en=1, threshold=8'hFF, timeout=3; raise bit 4 at cycle 20 -> COLLECT at 21, irq_out=1 at 25, event_cnt=1.
- W1C clear during COLLECT and ASSERT:
  - Status drops to 0 in COLLECT -> IDLE next cycle, event_cnt=0, irq_out never asserts.
  - Status drops to 0 in ASSERT -> irq_out=0 next cycle without irq_ack.
- Masking and saturation:
  - enable=8'h00 with status=8'hFF -> stays in IDLE.
  - CNT_WIDTH=2, threshold=3, timeout=3, 8 rises in COLLECT -> event_cnt saturates at 3 and does not wrap.
- Async reset: assert RegReset mid-COLLECT and mid-ASSERT, asynchronous to RegClk -> irq_out, irq_src, event_cnt, irq_state all 0 immediately, and the block resumes normally after release.
